sprite_dispatcher: RTL and testbench
====================================

Name: sprite_dispatcher

Overview:
- Host-side initiator for the sprite request handshake; the sprite communicator/blitter sequencer is the responder.
- Buffers sprite draw commands (2-bit sprite IDs) from game logic in a small FIFO.
- Issues the commands one at a time over the four-phase incoming/received/finished/acknowledge protocol.
- Counts completed sprites and flags a stuck responder with a watchdog.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TIMEOUT, 1048576, cycles allowed in WAIT_FIN before timeout_err sets.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- cmd_valid  in  1  game logic presents a command
- cmd_num  in  2  sprite ID to draw
- cmd_ready  out  1  FIFO can accept; equals not full
- flush  in  1  discards queued (not yet issued) commands
- err_clear  in  1  clears timeout_err
- sprite_incoming  out  1  request to responder
- sprite_num  out  2  ID of the in-flight request; stable while not IDLE
- sprite_received  in  1  responder has latched the request
- sprite_finished  in  1  responder has completed the draw
- acknowledge_finished_sprite  out  1  acknowledges sprite_finished
- busy  out  1  high when state is not IDLE or the FIFO is non-empty
- fifo_count  out  clog2(DEPTH)+1  number of queued entries
- done_count  out  16  completed sprites; wraps at 65535 to 0
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (async): state IDLE, FIFO empty, cur_num=0, done_count=0, watchdog=0, timeout_err=0.
- Reset values of outputs: sprite_incoming=0, ack=0, sprite_num=0, cmd_ready=1, busy=0, fifo_count=0.
- Handshake outputs are Moore outputs decoded from the registered state; sprite_num is driven from register cur_num.
- FIFO push: on the edge where cmd_valid & cmd_ready. cmd_ready depends only on full, not on a same-cycle pop.
- FIFO pop: when IDLE and non-empty. The head is loaded into cur_num on the same edge, and the state goes to REQ.
- Push and pop on the same edge: both happen, and fifo_count is unchanged.
- Pointers wrap modulo DEPTH.
- flush: on the edge, empties the FIFO (count=0, pointers equal) and has priority over a same-edge push. It does not affect an in-flight request or the state.
- States:
  - IDLE: incoming=0, ack=0. Non-empty -> REQ (pop).
  - REQ: incoming=1. sprite_received=1 -> DROP.
  - DROP: incoming=0. sprite_received=0 -> WAIT_FIN.
  - WAIT_FIN: incoming=0. sprite_finished=1 -> ACK.
  - ACK: ack=1. sprite_finished=0 -> IDLE, and done_count increments on that edge.
- ack is held until the responder drops sprite_finished. It is low in IDLE, so at least one cycle with ack=0 always precedes the next incoming.
- Latency: a command accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. sprite_incoming is high in the cycle after edge N+1.
- Against the standard responder, REQ lasts 2 cycles (responder WAIT then READ_SPRITE).
- Watchdog:
  - Counts cycles spent in WAIT_FIN and clears on leaving WAIT_FIN.
  - When it reaches TIMEOUT, timeout_err sets and the counter saturates.
  - The FSM keeps waiting: no abort, because the responder may still be writing.
  - err_clear clears timeout_err; if err_clear and a set coincide, the set wins.
- Spurious inputs are ignored:
  - sprite_finished outside WAIT_FIN/ACK.
  - sprite_received outside REQ/DROP.
- Reset mid-transaction: returns to IDLE immediately and drops incoming/ack. The queue is lost.
- done_count increments only on ACK->IDLE.

Test Plan:
- Single command:
  - Stimulus: push cmd_num=2 and run against the responder model (received 1 cycle after incoming; finished 10 cycles after incoming drops).
  - Required: sprite_num=2 throughout, incoming high for 2 cycles, ack high until finished drops, done_count=1, busy returns to 0.
- Fill and overflow:
  - Stimulus: push 5 commands back-to-back with DEPTH=4 while the responder is stalled.
  - Required: the first is popped, the FIFO holds 4, cmd_ready=0 once full, extra pushes are ignored, and the IDs are issued in order.
- Simultaneous push and pop:
  - Stimulus: FIFO holds 1 entry, IDLE, and a push happens on the pop edge.
  - Required: fifo_count stays 1 and the next request carries the pushed ID.
- Flush:
  - Stimulus: queue IDs 1,2,3 while ID 0 is in flight, assert flush together with a push of 3.
  - Required: fifo_count=0, ID 0 completes, no further requests, done_count=1.
- Timeout:
  - Stimulus: TIMEOUT=16 and the responder never raises finished.
  - Required: timeout_err=1 after 16 cycles in WAIT_FIN and it stays sticky. err_clear with finished then raised drops the flag, and the ACK completes normally.
- Async reset mid-ACK:
  - Stimulus: assert Reset while ack=1.
  - Required: ack and incoming drop without waiting for a clock edge, and fifo_count=0, done_count=0.

Source files
------------

// File: rtl/sprite_dispatcher.sv
// sprite_dispatcher: queues sprite draw commands and issues them over the four-phase sprite handshake.
module sprite_dispatcher #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1048576
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_num,
  output logic                     cmd_ready,
  input  logic                     flush,
  input  logic                     err_clear,
  output logic                     sprite_incoming,
  output logic [1:0]               sprite_num,
  input  logic                     sprite_received,
  input  logic                     sprite_finished,
  output logic                     acknowledge_finished_sprite,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              done_count,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, DROP, WAIT_FIN, ACK} state_t;
  state_t state, state_d;
  logic [1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [1:0] cur_num;
  logic [WW-1:0] wd;
  logic full, empty, push, pop, wd_hit;
  assign full   = count == (AW+1)'(DEPTH);
  assign empty  = count == '0;
  assign push   = cmd_valid & ~full;
  assign pop    = (state == IDLE) & ~empty;
  assign wd_hit = (state == WAIT_FIN) && (wd == WW'(TIMEOUT - 1));
  assign cmd_ready                   = ~full;
  assign fifo_count                  = count;
  assign sprite_num                  = cur_num;
  assign sprite_incoming             = state == REQ;
  assign acknowledge_finished_sprite = state == ACK;
  assign busy                        = (state != IDLE) | ~empty;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = empty ? IDLE : REQ;
      REQ:      state_d = sprite_received ? DROP : REQ;
      DROP:     state_d = sprite_received ? DROP : WAIT_FIN;
      WAIT_FIN: state_d = sprite_finished ? ACK : WAIT_FIN;
      ACK:      state_d = sprite_finished ? ACK : IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge Clk)
    if (push && !flush) mem[wr_ptr] <= cmd_num;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cur_num <= '0;
    end else begin
      if (pop) cur_num <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  // Watchdog only observes; the FSM keeps waiting because the responder may still be drawing.
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
      done_count  <= '0;
    end else begin
      wd          <= (state != WAIT_FIN) ? '0 : (wd == WW'(TIMEOUT)) ? wd : wd + 1'b1;
      timeout_err <= wd_hit ? 1'b1 : err_clear ? 1'b0 : timeout_err;
      done_count  <= done_count + 16'((state == ACK) & ~sprite_finished);
    end
endmodule

// File: tb/tb_sprite_dispatcher.sv
// tb_sprite_dispatcher: random commands against a responder model, checked by a transaction-level scoreboard.
module tb_sprite_dispatcher;
  logic Clk = 1'b0;
  logic Reset, cmd_valid, flush, err_clear, sprite_received, sprite_finished;
  logic [1:0] cmd_num;
  logic cmd_ready, sprite_incoming, acknowledge_finished_sprite, busy, timeout_err;
  logic [1:0] sprite_num;
  logic [2:0] fifo_count;
  logic [15:0] done_count;

  sprite_dispatcher #(.DEPTH(4), .TIMEOUT(16)) dut (
    .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_num(cmd_num), .cmd_ready(cmd_ready),
    .flush(flush), .err_clear(err_clear), .sprite_incoming(sprite_incoming), .sprite_num(sprite_num),
    .sprite_received(sprite_received), .sprite_finished(sprite_finished),
    .acknowledge_finished_sprite(acknowledge_finished_sprite), .busy(busy),
    .fifo_count(fifo_count), .done_count(done_count), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0, n_total = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: pending command queue plus the phase of the one transaction in flight.
  int q[$];
  bit inf, m_req, m_drop, m_wait, m_ack, m_err;
  int wcnt;
  logic [1:0] m_num;
  logic [15:0] m_done;
  int rph, rdly;

  task automatic model_reset();
    q.delete();
    {inf, m_req, m_drop, m_wait, m_ack, m_err} = '0;
    wcnt = 0; m_num = 0; m_done = 0; rph = 0; rdly = 0;
  endtask

  task automatic drive_idle();
    cmd_valid = 0; cmd_num = 0; flush = 0; err_clear = 0;
    sprite_received = 0; sprite_finished = 0;
  endtask

  initial begin
    drive_idle();
    Reset = 1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_incoming", sprite_incoming, 0);
    check("rst_ack", acknowledge_finished_sprite, 0);
    check("rst_sprite_num", sprite_num, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_done", done_count, 0);
    check("rst_err", timeout_err, 0);
    Reset = 0;
    model_reset();
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge Clk);
      check("fifo_count", fifo_count, q.size());
      check("cmd_ready", cmd_ready, q.size() < 4);
      check("busy", busy, inf || q.size() > 0);
      check("incoming", sprite_incoming, m_req);
      check("ack", acknowledge_finished_sprite, m_ack);
      check("sprite_num", sprite_num, m_num);
      check("done_count", done_count, m_done);
      check("timeout_err", timeout_err, m_err);
      if (acknowledge_finished_sprite && $urandom_range(0, 29) == 0) begin
        #2 Reset = 1;
        #1;
        check("arst_ack", acknowledge_finished_sprite, 0);
        check("arst_incoming", sprite_incoming, 0);
        check("arst_fifo_count", fifo_count, 0);
        check("arst_done", done_count, 0);
        check("arst_busy", busy, 0);
        drive_idle();
        @(negedge Clk);
        Reset = 0;
        model_reset();
        continue;
      end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_num   = 2'($urandom);
      flush     = $urandom_range(0, 31) == 0;
      err_clear = $urandom_range(0, 15) == 0;
      case (rph)
        0: if (sprite_incoming) begin
             sprite_finished = 0; rdly = $urandom_range(0, 2); rph = 1;
           end else sprite_finished = $urandom_range(0, 15) == 0;
        1: if (rdly == 0) begin sprite_received = 1; rph = 2; end else rdly--;
        2: if (!sprite_incoming) begin
             sprite_received = 0;
             rdly = ($urandom_range(0, 4) == 0) ? 30 : $urandom_range(0, 12);
             rph = 3;
           end
        3: if (rdly == 0) begin sprite_finished = 1; rph = 4; end else rdly--;
        4: if (acknowledge_finished_sprite) begin rdly = $urandom_range(0, 2); rph = 5; end
        default: if (rdly == 0) begin sprite_finished = 0; rph = 0; end else rdly--;
      endcase
      @(posedge Clk);
      begin
        bit pop_ok, set;
        int sz;
        pop_ok = !inf && q.size() > 0;
        sz = q.size();
        set = 0;
        if (m_ack && !sprite_finished) begin
          m_ack = 0; inf = 0; m_done++;
        end else if (m_wait) begin
          wcnt++;
          set = wcnt == 16;
          if (sprite_finished) begin m_wait = 0; m_ack = 1; end
        end else if (m_drop && !sprite_received) begin
          m_drop = 0; m_wait = 1; wcnt = 0;
        end else if (m_req && sprite_received) begin
          m_req = 0; m_drop = 1;
        end
        m_err = set ? 1'b1 : err_clear ? 1'b0 : m_err;
        if (pop_ok) begin m_num = 2'(q.pop_front()); inf = 1; m_req = 1; end
        if (flush) q.delete();
        else if (cmd_valid && sz < 4) q.push_back(int'(cmd_num));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
